// File: rtl/fifo_pkg.sv
// Shared constants and types for the 32-entry FIFO storage/pointer stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // Occupancy values for the full and empty tests.
  localparam cnt_t CNT_FULL  = cnt_t'(DEPTH);
  localparam cnt_t CNT_EMPTY = '0;

endpackage

// File: rtl/fifo_ram_sp.sv
// DEPTH x DATA_W storage array: one write port, one registered read port.
// Latency: read data appears 1 clock after re is sampled high; writes land at the edge.
// Backpressure: none; the caller guarantees that a read and a write never target the same live entry.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset (read register only)
//   we, waddr      write strobe and address; wdata is stored on the edge
//   re, raddr      read strobe and address; rdata updates on the edge and holds otherwise
module fifo_ram_sp
  import fifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  logic  re,
  input  addr_t raddr,
  output data_t rdata
);

  // The array is deliberately not reset; its contents are meaningless until written.
  data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The output register is reset so data_out reads 0 after reset, and it holds
  // its value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_storage_ctrl.sv
// Storage and pointer stage of the 32-entry FIFO: data array, circular addresses, occupancy count.
// Latency: accepted read returns data_out with data_valid 1 clock after the accepting edge.
// Backpressure: writes refused when full (wr_drop), reads refused when empty (rd_drop); both re-checked here.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   wr, data_in         write request and write data
//   rd_en               read request (pre-gated upstream, gated again here)
//   wr_ptr              registered occupancy count 0..DEPTH
//   data_out/data_valid registered read data and its one-cycle strobe
//   wr_drop/rd_drop     one-cycle pulses for refused writes/reads
module fifo_storage_ctrl
  import fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [CNT_W-1:0]  wr_ptr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              wr_drop,
  output logic              rd_drop
);

  addr_t wr_addr;
  addr_t rd_addr;
  logic  full;
  logic  empty;
  logic  wr_acc;
  logic  rd_acc;

  // Acceptance uses the pre-edge count. Since a read is only refused at count 0,
  // a write and a read can never hit the same live address in one cycle.
  assign full   = (wr_ptr == CNT_FULL);
  assign empty  = (wr_ptr == CNT_EMPTY);
  assign wr_acc = wr & ~full;
  assign rd_acc = rd_en & ~empty;

  fifo_ram_sp u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_addr),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_addr),
    .rdata (data_out)
  );

  // Addresses wrap naturally at ADDR_W bits, giving modulo-DEPTH behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      if (wr_acc) begin
        wr_addr <= wr_addr + addr_t'(1);
      end
      if (rd_acc) begin
        rd_addr <= rd_addr + addr_t'(1);
      end
    end
  end

  // Count moves only when exactly one side is accepted; the acceptance gating
  // keeps it within 0..DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_acc && !rd_acc) begin
      wr_ptr <= wr_ptr + cnt_t'(1);
    end else if (rd_acc && !wr_acc) begin
      wr_ptr <= wr_ptr - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid <= 1'b0;
      wr_drop    <= 1'b0;
      rd_drop    <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      wr_drop    <= wr & full;
      rd_drop    <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_fifo_storage_ctrl.sv
// Self-checking bench for fifo_storage_ctrl: queue-based reference model plus directed literal checks.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fifo_storage_ctrl;

  logic       clk;
  logic       rst;
  logic       wr;
  logic [7:0] data_in;
  logic       rd_en;
  logic [5:0] wr_ptr;
  logic [7:0] data_out;
  logic       data_valid;
  logic       wr_drop;
  logic       rd_drop;

  int checks;
  int failures;
  bit model_on;

  // Reference model: the FIFO contents as a queue plus the expected registered outputs.
  logic [7:0] q[$];
  logic [7:0] exp_dout;
  bit         exp_dv;
  bit         exp_wdrop;
  bit         exp_rdrop;

  fifo_storage_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .data_in    (data_in),
    .rd_en      (rd_en),
    .wr_ptr     (wr_ptr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .wr_drop    (wr_drop),
    .rd_drop    (rd_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model update at each rising edge, using the inputs as they stand before the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_dout  = 8'h00;
      exp_dv    = 1'b0;
      exp_wdrop = 1'b0;
      exp_rdrop = 1'b0;
    end else begin
      bit was_full;
      bit was_empty;
      was_full  = (q.size() == 32);
      was_empty = (q.size() == 0);
      exp_wdrop = wr && was_full;
      exp_rdrop = rd_en && was_empty;
      exp_dv    = rd_en && !was_empty;
      if (rd_en && !was_empty) exp_dout = q.pop_front();
      if (wr && !was_full) q.push_back(data_in);
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (model_on && !rst) begin
      chk("m_count", int'(wr_ptr), q.size());
      chk("m_valid", int'(data_valid), int'(exp_dv));
      chk("m_dout", int'(data_out), int'(exp_dout));
      chk("m_wdrop", int'(wr_drop), int'(exp_wdrop));
      chk("m_rdrop", int'(rd_drop), int'(exp_rdrop));
    end
  end

  // One clock of stimulus; inputs are changed 1 ns after the rising edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr = w; data_in = d; rd_en = r;
    @(posedge clk);
    #1;
    wr = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    int wn;
    int rn;
    int cnt;
    int guard;
    bit w;
    bit r;
    logic [7:0] hold;

    checks = 0; failures = 0; model_on = 1'b0;
    wr = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", int'(wr_ptr), 0);
    chk("reset_valid", int'(data_valid), 0);
    chk("reset_dout", int'(data_out), 0);
    chk("reset_drops", int'({wr_drop, rd_drop}), 0);
    rst = 1'b0;
    model_on = 1'b1;

    // Fill with 0x00..0x1F, then one write too many.
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("fill_count", int'(wr_ptr), 32);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("overflow_drop", int'(wr_drop), 1);
    chk("overflow_count", int'(wr_ptr), 32);

    // Drain: each word appears one cycle after its read request, in order.
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_valid", int'(data_valid), 1);
      chk("drain_data", int'(data_out), i);
    end
    chk("drain_count", int'(wr_ptr), 0);

    // Empty read is refused and data_out holds.
    cyc(1'b0, 8'h00, 1'b1);
    chk("empty_rdrop", int'(rd_drop), 1);
    chk("empty_valid", int'(data_valid), 0);
    chk("empty_count", int'(wr_ptr), 0);
    chk("empty_dout_hold", int'(data_out), 31);

    // Simultaneous at count 0: write wins, read refused, no fall-through.
    cyc(1'b1, 8'h40, 1'b1);
    chk("sim0_count", int'(wr_ptr), 1);
    chk("sim0_rdrop", int'(rd_drop), 1);
    chk("sim0_valid", int'(data_valid), 0);

    // Fill to 32 (oldest word is 0x40), then simultaneous at full.
    for (int i = 1; i < 32; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    chk("refill_count", int'(wr_ptr), 32);
    cyc(1'b1, 8'hEE, 1'b1);
    chk("simfull_count", int'(wr_ptr), 31);
    chk("simfull_wdrop", int'(wr_drop), 1);
    chk("simfull_dout", int'(data_out), 8'h40);

    // Bring the count to 10 and do a simultaneous read and write.
    for (int i = 0; i < 21; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("ten_count", int'(wr_ptr), 10);
    cyc(1'b1, 8'h77, 1'b1);
    chk("sim10_count", int'(wr_ptr), 10);
    chk("sim10_dout", int'(data_out), 8'h40 + 22);

    // Reset mid-stream at count 5 with a read in flight.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0);
    chk("pre_reset_count", int'(wr_ptr), 5);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    chk("pre_reset_valid", int'(data_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_count", int'(wr_ptr), 0);
    chk("async_reset_valid", int'(data_valid), 0);
    chk("async_reset_dout", int'(data_out), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Wrap-around: 40 writes interleaved with 40 reads, count held within 1..8.
    wn = 0; rn = 0; cnt = 0; guard = 0;
    while ((wn < 40 || rn < 40) && guard < 1000) begin
      guard++;
      w = (wn < 40) && (cnt < 8) && (($urandom % 2 == 1) || cnt <= 1);
      r = (rn < 40) && (cnt >= 1) && (($urandom % 2 == 1) || wn == 40) && (cnt > 1 || w || wn == 40);
      cyc(w, 8'($urandom), r);
      if (w) wn++;
      if (r) rn++;
      cnt = cnt + int'(w) - int'(r);
    end
    chk("wrap_done", int'(wn == 40 && rn == 40), 1);
    chk("wrap_count", int'(wr_ptr), 0);

    // Random traffic in phases with different write/read mixes to hit full and empty.
    for (int ph = 0; ph < 6; ph++) begin
      int pw;
      int pr;
      pw = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
      pr = 100 - pw;
      for (int i = 0; i < 250; i++) begin
        hold = 8'($urandom);
        cyc(($urandom % 100) < pw, hold, ($urandom % 100) < pr);
      end
    end

    @(negedge clk);
    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
